// File: rtl/experiment_pkg.sv
// Shared definitions for the experiment event logger: event bit positions,
// record layout and record width.
package experiment_pkg;

    localparam int EV_DET_RISE     = 0;
    localparam int EV_DET_FALL     = 1;
    localparam int EV_TRIG_RISE    = 2;
    localparam int EV_TRIG_FALL    = 3;
    localparam int EV_READY_FALL   = 4;
    localparam int EV_READY_RISE   = 5;
    localparam int EV_STATE_CHANGE = 6;
    localparam int EV_COUNT        = 7;

    localparam int REC_WIDTH = 48;

    typedef struct packed {
        logic                rsvd;
        logic [EV_COUNT-1:0] event_mask;
        logic [7:0]          state;
        logic [31:0]         timestamp;
    } record_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; clear has priority over
// any simultaneous write or read.
module event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 48
) (
    input  logic                     clock,
    input  logic                     reset_signal,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (do_wr && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (!reset_signal || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/experiment_event_logger.sv
// Timestamped event logger: edge-detects experiment-phase signals and the
// synchronized detector status, packing simultaneous events into one record.
module experiment_event_logger
    import experiment_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 32
) (
    input  logic                        clock,
    input  logic                        reset_signal,
    input  logic                        arm,
    input  logic [7:0]                  scenario_state,
    input  logic                        detonation_signal,
    input  logic                        output_trigger,
    input  logic                        detector_ready,
    input  logic                        clear_log,
    input  logic                        rd_ack,
    output logic                        rd_valid,
    output logic [REC_WIDTH-1:0]        rd_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic [7:0]                  dropped_count,
    output logic [TS_WIDTH-1:0]         timestamp
);

    logic                ready_meta;
    logic                ready_sync;
    logic                ready_q;
    logic                detonation_q;
    logic                trigger_q;
    logic                arm_q;
    logic [7:0]          state_q;
    logic                primed;
    logic [EV_COUNT-1:0] event_mask;
    logic                log_write;
    logic                arm_rise;
    logic                drop;
    logic                full;
    logic                empty;
    record_t             rec;

    // History is captured for one cycle after reset before any edge counts.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            ready_meta   <= 1'b0;
            ready_sync   <= 1'b0;
            ready_q      <= 1'b0;
            detonation_q <= 1'b0;
            trigger_q    <= 1'b0;
            arm_q        <= 1'b0;
            state_q      <= '0;
            primed       <= 1'b0;
        end else begin
            ready_meta   <= detector_ready;
            ready_sync   <= ready_meta;
            ready_q      <= ready_sync;
            detonation_q <= detonation_signal;
            trigger_q    <= output_trigger;
            arm_q        <= arm;
            state_q      <= scenario_state;
            primed       <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: defaults first keep this block free of inferred latches.
        event_mask = '0;
        if (primed) begin
            event_mask[EV_DET_RISE]     = detonation_signal & ~detonation_q;
            event_mask[EV_DET_FALL]     = ~detonation_signal & detonation_q;
            event_mask[EV_TRIG_RISE]    = output_trigger & ~trigger_q;
            event_mask[EV_TRIG_FALL]    = ~output_trigger & trigger_q;
            event_mask[EV_READY_FALL]   = ~ready_sync & ready_q;
            event_mask[EV_READY_RISE]   = ready_sync & ~ready_q;
            event_mask[EV_STATE_CHANGE] = (scenario_state != state_q);
        end
    end

    assign log_write = arm && (event_mask != '0);
    assign arm_rise  = primed && arm && !arm_q;
    // A full buffer with a simultaneous pop still accepts the record.
    assign drop      = log_write && !clear_log && full && !rd_ack;

    assign rec.rsvd       = 1'b0;
    assign rec.event_mask = event_mask;
    assign rec.state      = scenario_state;
    assign rec.timestamp  = 32'(timestamp);

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_WIDTH)
    ) u_fifo (
        .clock        (clock),
        .reset_signal (reset_signal),
        .clear        (clear_log),
        .wr_en        (log_write),
        .rd_en        (rd_ack),
        .wr_data      (rec),
        .rd_data      (rd_data),
        .count        (fifo_count),
        .full         (full),
        .empty        (empty)
    );

    assign rd_valid = !empty;

    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            timestamp     <= '0;
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else begin
            if (arm_rise) begin
                timestamp <= '0;
            end else if (arm && !(&timestamp)) begin
                timestamp <= timestamp + TS_WIDTH'(1);
            end

            if (clear_log) begin
                overflow      <= 1'b0;
                dropped_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (dropped_count != 8'hFF) dropped_count <= dropped_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_experiment_event_logger.sv
// Self-checking bench: directed scenarios plus randomized traffic, checked
// against a behavioural queue model by a negedge monitor.
module tb_experiment_event_logger;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset_signal;
    logic        arm;
    logic [7:0]  scenario_state;
    logic        detonation_signal;
    logic        output_trigger;
    logic        detector_ready;
    logic        clear_log;
    logic        rd_ack;
    logic        rd_valid;
    logic [47:0] rd_data;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [7:0]  dropped_count;
    logic [31:0] timestamp;

    always #5 clock = ~clock;

    experiment_event_logger #(
        .FIFO_DEPTH (DEPTH),
        .TS_WIDTH   (32)
    ) dut (
        .clock             (clock),
        .reset_signal      (reset_signal),
        .arm               (arm),
        .scenario_state    (scenario_state),
        .detonation_signal (detonation_signal),
        .output_trigger    (output_trigger),
        .detector_ready    (detector_ready),
        .clear_log         (clear_log),
        .rd_ack            (rd_ack),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .fifo_count        (fifo_count),
        .overflow          (overflow),
        .dropped_count     (dropped_count),
        .timestamp         (timestamp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: the buffer is a queue of expected records.
    logic [47:0] exp_q[$];
    logic [31:0] m_ts      = '0;
    logic        m_ovf     = 1'b0;
    int          m_drop    = 0;
    bit          m_primed  = 0;
    logic        m_arm_q   = 1'b0;
    logic        m_det_q   = 1'b0;
    logic        m_trig_q  = 1'b0;
    logic [7:0]  m_state_q = '0;
    logic        r_samp [3] = '{1'b0, 1'b0, 1'b0};  // detector samples from 1, 2, 3 edges ago
    bit          mon_en    = 0;

    always @(posedge clock) begin : model
        logic [6:0] mask;
        logic       ready_now;
        logic       ready_prev;
        bit         wr;
        bit         pop;
        bit         arm_rise;
        mon_en = 1;
        if (!reset_signal) begin
            exp_q.delete();
            m_ts = '0; m_ovf = 1'b0; m_drop = 0; m_primed = 0;
            m_arm_q = 1'b0; m_det_q = 1'b0; m_trig_q = 1'b0; m_state_q = '0;
            r_samp[0] = 1'b0; r_samp[1] = 1'b0; r_samp[2] = 1'b0;
        end else begin
            // The logger sees detector_ready two sampling edges late.
            ready_now  = r_samp[1];
            ready_prev = r_samp[2];
            mask = '0;
            if (m_primed) begin
                mask[0] = detonation_signal && !m_det_q;
                mask[1] = !detonation_signal && m_det_q;
                mask[2] = output_trigger && !m_trig_q;
                mask[3] = !output_trigger && m_trig_q;
                mask[4] = !ready_now && ready_prev;
                mask[5] = ready_now && !ready_prev;
                mask[6] = scenario_state != m_state_q;
            end
            wr       = arm && (mask != 0);
            arm_rise = m_primed && arm && !m_arm_q;
            if (clear_log) begin
                exp_q.delete();
                m_ovf  = 1'b0;
                m_drop = 0;
            end else begin
                pop = rd_ack && (exp_q.size() > 0);
                if (wr && exp_q.size() == DEPTH && !pop) begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end else begin
                    if (pop) void'(exp_q.pop_front());
                    if (wr) exp_q.push_back({1'b0, mask, scenario_state, m_ts});
                end
            end
            if (arm_rise) m_ts = '0;
            else if (arm && m_ts != 32'hFFFF_FFFF) m_ts = m_ts + 1;
            m_arm_q = arm; m_det_q = detonation_signal; m_trig_q = output_trigger;
            m_state_q = scenario_state; m_primed = 1;
            r_samp[2] = r_samp[1]; r_samp[1] = r_samp[0]; r_samp[0] = detector_ready;
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            check("rd_valid", rd_valid, exp_q.size() != 0);
            check("fifo_count", fifo_count, exp_q.size());
            check("overflow", overflow, m_ovf);
            check("dropped_count", dropped_count, m_drop);
            check("timestamp", timestamp, m_ts);
            if (exp_q.size() != 0) check("rd_data", rd_data, exp_q[0]);
        end
    end

    task automatic toggle_trigger(input int n);
        for (int i = 0; i < n; i++) begin
            output_trigger = ~output_trigger;
            @(negedge clock);
        end
    endtask

    task automatic pulse_clear();
        clear_log = 1'b1;
        @(negedge clock);
        clear_log = 1'b0;
    endtask

    initial begin
        reset_signal = 1'b0; arm = 1'b0; scenario_state = '0; detonation_signal = 1'b0;
        output_trigger = 1'b0; detector_ready = 1'b0; clear_log = 1'b0; rd_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_count", fifo_count, 0);
        check("reset_ts", timestamp, 0);
        check("reset_valid", rd_valid, 0);
        check("reset_ovf", overflow, 0);
        reset_signal = 1'b1;
        repeat (2) @(negedge clock);

        // Session start, detonation high for 200 cycles.
        arm = 1'b1;
        repeat (10) @(negedge clock);
        detonation_signal = 1'b1;
        @(negedge clock);
        check("det_rise_rec", rd_data, {1'b0, 7'h01, 8'h00, 32'd9});
        repeat (199) @(negedge clock);
        detonation_signal = 1'b0;
        @(negedge clock);
        check("two_recs", fifo_count, 2);
        rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
        check("det_fall_rec", rd_data, {1'b0, 7'h02, 8'h00, 32'd209});
        rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
        check("drained_valid", rd_valid, 0);

        // Coincident events share one record.
        pulse_clear();
        detonation_signal = 1'b1;
        @(negedge clock);
        detonation_signal = 1'b0; output_trigger = 1'b1; scenario_state = 8'h5A; rd_ack = 1'b1;
        @(negedge clock);
        rd_ack = 1'b0;
        check("combo_mask", rd_data[46:40], 7'h46);
        check("combo_state", rd_data[39:32], 8'h5A);
        check("combo_count", fifo_count, 1);

        // Overflow: 17 events into 16 slots, then saturation of the drop count.
        pulse_clear();
        toggle_trigger(17);
        check("ovf_count", fifo_count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_dropped", dropped_count, 1);
        toggle_trigger(260);
        check("drop_saturate", dropped_count, 255);

        // Full buffer with simultaneous write and pop.
        pulse_clear();
        toggle_trigger(16);
        check("full_count", fifo_count, 16);
        rd_ack = 1'b1;
        output_trigger = ~output_trigger;
        @(negedge clock);
        rd_ack = 1'b0;
        check("full_wr_pop_count", fifo_count, 16);
        check("full_wr_pop_ovf", overflow, 0);

        rd_ack = 1'b1;
        for (int i = 0; i < 40 && rd_valid; i++) @(negedge clock);
        rd_ack = 1'b0;
        check("drain_done", rd_valid, 0);

        // Asynchronous detector status through the synchronizer.
        #3 detector_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("ready_latency", rd_valid, 0);
        @(negedge clock);
        check("ready_rise_valid", rd_valid, 1);
        check("ready_rise_mask", rd_data[46:40], 7'h20);
        #3 detector_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("ready_fall_count", fifo_count, 2);
        pulse_clear();
        check("clear_valid", rd_valid, 0);
        check("clear_count", fifo_count, 0);

        // Reset mid-session with records buffered.
        toggle_trigger(5);
        check("pre_reset_count", fifo_count, 5);
        reset_signal = 1'b0;
        @(negedge clock);
        reset_signal = 1'b1;
        check("mid_reset_count", fifo_count, 0);
        check("mid_reset_ts", timestamp, 0);
        repeat (5) @(negedge clock);
        check("no_spurious", rd_valid, 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(99) < 3) arm = ~arm;
            if ($urandom_range(3) == 0) detonation_signal = ~detonation_signal;
            if ($urandom_range(3) == 0) output_trigger = ~output_trigger;
            if ($urandom_range(9) == 0) scenario_state = 8'($urandom);
            rd_ack       = ($urandom_range(99) < ((c % 1000) < 500 ? 25 : 70));
            clear_log    = ($urandom_range(299) == 0);
            reset_signal = !($urandom_range(699) == 0);
            if ($urandom_range(1) == 1) #($urandom_range(6, 9));
            else #($urandom_range(1, 4));
            if ($urandom_range(4) == 0) detector_ready = ~detector_ready;
            @(negedge clock);
        end

        reset_signal = 1'b1; clear_log = 1'b0; rd_ack = 1'b0;
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
